// File: rtl/grouped_update_scheduler.sv
// Steps colour groups 0..NUM_GROUPS-1 for chromatic Gibbs sampling: each group is live for a
// dwell window, separated by guard gaps, for a counted number of sweeps or until stopped.
module grouped_update_scheduler #(
  parameter int NUM_GROUPS   = 3,
  parameter int GROUP_W      = 3,
  parameter int DWELL_CYCLES = 4,
  parameter int GAP_CYCLES   = 1,
  parameter int SWEEP_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [SWEEP_W-1:0] num_sweeps,
  output logic [GROUP_W-1:0] group_EN,
  output logic               update_valid,
  output logic               busy,
  output logic               done,
  output logic [SWEEP_W-1:0] sweep_count
);

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_GAP, S_DONE} state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0]   DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GROUP_W-1:0] LAST_GROUP = GROUP_W'(NUM_GROUPS - 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_dwell, w_dwell_nxt;
  logic [CNT_W-1:0]   r_gap, w_gap_nxt;
  logic [GROUP_W-1:0] r_group, w_group_nxt;
  logic [SWEEP_W-1:0] r_sweep, w_sweep_nxt;
  logic [SWEEP_W-1:0] r_num, w_num_nxt;
  logic               r_valid, r_busy, r_done;
  logic               w_valid_nxt, w_busy_nxt, w_done_nxt;

  logic               w_start_ok, w_dwell_end, w_sweep_end, w_run_done;
  logic [SWEEP_W-1:0] w_sweep_inc;
  logic [GROUP_W-1:0] w_group_succ;

  assign w_start_ok   = (r_state == S_IDLE) && start && !stop;
  assign w_dwell_end  = (r_state == S_DWELL) && (r_dwell == DWELL_LAST);
  // A sweep only counts once its last group has completed its full dwell without a stop.
  assign w_sweep_end  = w_dwell_end && (r_group == LAST_GROUP) && !stop;
  assign w_sweep_inc  = r_sweep + 1'b1;
  assign w_run_done   = w_sweep_end && (r_num != '0) && (w_sweep_inc == r_num);
  assign w_group_succ = (r_group == LAST_GROUP) ? '0 : r_group + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_DWELL;
      S_DWELL: begin
        if (stop)                    w_state_nxt = S_IDLE;
        else if (w_dwell_end) begin
          if (w_run_done)            w_state_nxt = S_DONE;
          else if (GAP_CYCLES == 0)  w_state_nxt = S_DWELL;
          else                       w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (stop)                    w_state_nxt = S_IDLE;
        else if (r_gap == GAP_LAST)  w_state_nxt = S_DWELL;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and counters, derived from the next state so every
  // output lines up with the state it describes.
  always_comb begin
    w_valid_nxt = (w_state_nxt == S_DWELL);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_done_nxt  = (w_state_nxt == S_DONE);
    w_group_nxt = r_group;
    if ((w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE)) begin
      w_group_nxt = '0;
    end else if (w_dwell_end) begin
      w_group_nxt = w_group_succ;
    end
    w_dwell_nxt = '0;
    if ((r_state == S_DWELL) && (w_state_nxt == S_DWELL) && !w_dwell_end) begin
      w_dwell_nxt = r_dwell + 1'b1;
    end
    w_gap_nxt = '0;
    if ((r_state == S_GAP) && (w_state_nxt == S_GAP)) begin
      w_gap_nxt = r_gap + 1'b1;
    end
    w_sweep_nxt = r_sweep;
    if (w_start_ok)       w_sweep_nxt = '0;
    else if (w_sweep_end) w_sweep_nxt = w_sweep_inc;
    w_num_nxt = w_start_ok ? num_sweeps : r_num;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dwell <= '0;
      r_gap   <= '0;
      r_group <= '0;
      r_sweep <= '0;
      r_num   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_dwell <= w_dwell_nxt;
      r_gap   <= w_gap_nxt;
      r_group <= w_group_nxt;
      r_sweep <= w_sweep_nxt;
      r_num   <= w_num_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign group_EN     = r_group;
  assign update_valid = r_valid;
  assign busy         = r_busy;
  assign done         = r_done;
  assign sweep_count  = r_sweep;

endmodule

// File: tb/tb_grouped_update_scheduler.sv
// Scoreboard bench: stimulus pushes the expected (cycle, group, sweep) of every live cycle and
// every done pulse; monitors pop and compare whenever an instance shows update_valid or done.
module tb_grouped_update_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_start, a_stop, b_start, b_stop;
  logic [15:0] a_num, b_num;
  logic [2:0]  a_grp, b_grp;
  logic        a_uv, a_busy, a_done, b_uv, b_busy, b_done;
  logic [15:0] a_swp, b_swp;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    bit is_done;
    int grp;
    int swp;
    int at;
  } evt_t;

  evt_t qa[$];
  evt_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  grouped_update_scheduler u_a (
    .clk(clk), .rst(rst), .start(a_start), .stop(a_stop), .num_sweeps(a_num),
    .group_EN(a_grp), .update_valid(a_uv), .busy(a_busy), .done(a_done), .sweep_count(a_swp)
  );

  grouped_update_scheduler #(.DWELL_CYCLES(1), .GAP_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .stop(b_stop), .num_sweeps(b_num),
    .group_EN(b_grp), .update_valid(b_uv), .busy(b_busy), .done(b_done), .sweep_count(b_swp)
  );

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Expected events for a run starting with its first live cycle at t0; events later than
  // 'limit' are left out for runs cut short by stop or reset.
  task automatic push_run(input bit inst_b, input int t0, input int sweeps, input bit counted,
                          input int dwell, input int gap, input int limit);
    int t;
    evt_t e;
    t = t0;
    for (int s = 0; s < sweeps; s++) begin
      for (int g = 0; g < 3; g++) begin
        for (int d = 0; d < dwell; d++) begin
          e.is_done = 1'b0; e.grp = g; e.swp = s; e.at = t;
          if (t <= limit) begin
            if (inst_b) qb.push_back(e); else qa.push_back(e);
          end
          t++;
        end
        if (!(counted && s == sweeps - 1 && g == 2)) t += gap;
      end
    end
    if (counted && t <= limit) begin
      e.is_done = 1'b1; e.grp = 0; e.swp = sweeps; e.at = t;
      if (inst_b) qb.push_back(e); else qa.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (a_uv || a_done) begin
      if (qa.size() == 0) begin
        chk("A_unexpected_output", 1, 0);
      end else begin
        evt_t e;
        e = qa.pop_front();
        chk("A_cycle", cyc, e.at);
        chk("A_done", int'(a_done), int'(e.is_done));
        chk("A_valid", int'(a_uv), int'(!e.is_done));
        chk("A_group", int'(a_grp), e.grp);
        chk("A_sweep", int'(a_swp), e.swp);
        chk("A_busy", int'(a_busy), 1);
      end
    end
  end

  always @(negedge clk) begin
    if (b_uv || b_done) begin
      if (qb.size() == 0) begin
        chk("B_unexpected_output", 1, 0);
      end else begin
        evt_t e;
        e = qb.pop_front();
        chk("B_cycle", cyc, e.at);
        chk("B_done", int'(b_done), int'(e.is_done));
        chk("B_group", int'(b_grp), e.grp);
        chk("B_sweep", int'(b_swp), e.swp);
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic chk_a_idle(input string nm, input int swp);
    chk({nm, "_valid"}, int'(a_uv), 0);
    chk({nm, "_group"}, int'(a_grp), 0);
    chk({nm, "_busy"}, int'(a_busy), 0);
    chk({nm, "_done"}, int'(a_done), 0);
    chk({nm, "_sweep"}, int'(a_swp), swp);
  endtask

  initial begin
    int c;
    rst = 1'b1; a_start = 1'b1; b_start = 1'b1; a_stop = 1'b0; b_stop = 1'b0;
    a_num = 16'd1; b_num = 16'd1;

    // Reset held three cycles with start asserted
    repeat (3) @(negedge clk);
    chk_a_idle("rst_a", 0);
    chk("rst_b_busy", int'(b_busy), 0);
    chk("rst_b_valid", int'(b_uv), 0);
    rst = 1'b0; a_start = 1'b0; b_start = 1'b0;
    repeat (3) @(negedge clk);
    chk_a_idle("post_rst_a", 0);
    chk("post_rst_b_busy", int'(b_busy), 0);

    // Two counted sweeps with default timing
    c = cyc;
    a_num = 16'd2; a_start = 1'b1;
    push_run(1'b0, c + 1, 2, 1'b1, 4, 1, 1 << 30);
    @(negedge clk) a_start = 1'b0;
    wait_cyc(c + 30);
    chk("run2_busy_at_done", int'(a_busy), 1);
    @(negedge clk);
    chk_a_idle("run2_end", 2);
    chk("run2_queue_left", qa.size(), 0);

    // No gap, single-cycle dwell, one sweep
    c = cyc;
    b_num = 16'd1; b_start = 1'b1;
    push_run(1'b1, c + 1, 1, 1'b1, 1, 0, 1 << 30);
    @(negedge clk) b_start = 1'b0;
    wait_cyc(c + 6);
    chk("b_end_busy", int'(b_busy), 0);
    chk("b_end_sweep", int'(b_swp), 1);
    chk("b_queue_left", qb.size(), 0);

    // Free-run, stopped during group 1 of the third sweep
    c = cyc;
    a_num = 16'd0; a_start = 1'b1;
    push_run(1'b0, c + 1, 3, 1'b0, 4, 1, c + 1 + 36);
    @(negedge clk) a_start = 1'b0;
    wait_cyc(c + 1 + 36);
    a_stop = 1'b1;
    @(negedge clk) a_stop = 1'b0;
    chk_a_idle("stop", 2);
    repeat (3) @(negedge clk);
    chk_a_idle("stop_hold", 2);
    chk("stop_queue_left", qa.size(), 0);

    // start together with stop is refused
    a_num = 16'd1; a_start = 1'b1; a_stop = 1'b1;
    @(negedge clk) begin a_start = 1'b0; a_stop = 1'b0; end
    chk_a_idle("start_stop", 2);
    @(negedge clk);
    chk_a_idle("start_stop_hold", 2);

    // start and num_sweeps changes while busy are ignored
    c = cyc;
    a_num = 16'd1; a_start = 1'b1;
    push_run(1'b0, c + 1, 1, 1'b1, 4, 1, 1 << 30);
    @(negedge clk) a_start = 1'b0;
    wait_cyc(c + 6);
    a_start = 1'b1; a_num = 16'd5;
    @(negedge clk) a_start = 1'b0;
    wait_cyc(c + 17);
    chk_a_idle("midstart_end", 1);
    chk("midstart_queue_left", qa.size(), 0);

    // Reset in the middle of a dwell, then a clean run
    c = cyc;
    a_num = 16'd2; a_start = 1'b1;
    push_run(1'b0, c + 1, 2, 1'b1, 4, 1, c + 3);
    @(negedge clk) a_start = 1'b0;
    wait_cyc(c + 3);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk_a_idle("midrst", 0);
    chk("midrst_queue_left", qa.size(), 0);
    c = cyc;
    a_num = 16'd1; a_start = 1'b1;
    push_run(1'b0, c + 1, 1, 1'b1, 4, 1, 1 << 30);
    @(negedge clk) a_start = 1'b0;
    wait_cyc(c + 17);
    chk_a_idle("after_rst_run", 1);
    chk("after_rst_queue_left", qa.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
